// File: rtl/correction_pkg.sv
// correction_pkg: shared widths, base encoding and filter FSM states for the correction pipeline
package correction_pkg;
  localparam int MAX_READ_BIT_WIDTH = 8;
  localparam int MAX_KMER_BIT_WIDTH = 6;
  localparam int EXTENSION_WIDTH = 5;
  localparam int MIN_KMER_WIDTH = 12;
  localparam int MAX_READ_WIDTH = 2 ** MAX_READ_BIT_WIDTH;
  localparam int MAX_KMER_WIDTH = 2 ** MAX_KMER_BIT_WIDTH;
  localparam int CANDIDATE_REGISTER_WIDTH = MAX_READ_WIDTH + EXTENSION_WIDTH + MAX_KMER_WIDTH - MIN_KMER_WIDTH;
  localparam int KB = 2 * MAX_KMER_WIDTH;
  localparam int CB = 2 * (CANDIDATE_REGISTER_WIDTH + EXTENSION_WIDTH);
  localparam int PB = MAX_READ_BIT_WIDTH + 1;
  typedef enum logic [1:0] {BASE_A = 2'b00, BASE_C = 2'b01, BASE_G = 2'b10, BASE_T = 2'b11} base_t;
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, EMIT} state_t;
endpackage

// File: rtl/solid_priority_pick.sv
// solid_priority_pick: lowest set index of a 4-bit mask and whether no higher bit remains
module solid_priority_pick (
  input  logic [3:0] mask,
  output logic [1:0] idx,
  output logic       last
);
  // priority encode from bit 0 upward; last when the picked bit is the only one left at or above idx
  always_comb begin
    idx = mask[0] ? 2'd0 : mask[1] ? 2'd1 : mask[2] ? 2'd2 : 2'd3;
    last = (mask >> idx) == 4'd1;
  end
endmodule

// File: rtl/candidate_solidity_filter.sv
// candidate_solidity_filter: checks four k-mers against the solidity oracle and forwards solid candidates
// Optional CANDIDATE_FILTER_STATS_EN adds saturating stat_groups / stat_dropped counters.
module candidate_solidity_filter
  import correction_pkg::*;
#(
  parameter int MAX_READ_BIT_WIDTH = 8,
  parameter int MAX_KMER_BIT_WIDTH = 6,
  parameter int EXTENSION_WIDTH = 5,
  parameter int MIN_KMER_WIDTH = 12,
  parameter int MAX_READ_WIDTH = 2 ** MAX_READ_BIT_WIDTH,
  parameter int MAX_KMER_WIDTH = 2 ** MAX_KMER_BIT_WIDTH,
  parameter int CANDIDATE_REGISTER_WIDTH = MAX_READ_WIDTH + EXTENSION_WIDTH + MAX_KMER_WIDTH - MIN_KMER_WIDTH,
  localparam int KBW = 2 * MAX_KMER_WIDTH,
  localparam int CBW = 2 * (CANDIDATE_REGISTER_WIDTH + EXTENSION_WIDTH),
  localparam int PBW = MAX_READ_BIT_WIDTH + 1
) (
`ifdef CANDIDATE_FILTER_STATS_EN
  output logic [15:0] stat_groups,
  output logic [15:0] stat_dropped,
`endif
  input  logic clk,
  input  logic rstb,
  input  logic ip_valid,
  output logic ready4_ip,
  input  logic [KBW-1:0] kmerCandidate0,
  input  logic [KBW-1:0] kmerCandidate1,
  input  logic [KBW-1:0] kmerCandidate2,
  input  logic [KBW-1:0] kmerCandidate3,
  input  logic [2*CANDIDATE_REGISTER_WIDTH-1:-2*EXTENSION_WIDTH] candidate0,
  input  logic [2*CANDIDATE_REGISTER_WIDTH-1:-2*EXTENSION_WIDTH] candidate1,
  input  logic [2*CANDIDATE_REGISTER_WIDTH-1:-2*EXTENSION_WIDTH] candidate2,
  input  logic [2*CANDIDATE_REGISTER_WIDTH-1:-2*EXTENSION_WIDTH] candidate3,
  input  logic [PBW-1:0] position,
  input  logic direction,
  output logic lookup_req,
  output logic [KBW-1:0] lookup_kmer,
  input  logic lookup_ack,
  input  logic lookup_rsp_valid,
  input  logic lookup_rsp_solid,
  output logic op_valid,
  input  logic ready4_op,
  output logic [CBW-1:0] candidate_out,
  output logic [PBW-1:0] position_out,
  output logic op_last,
  output logic group_empty
);
  state_t state;
  logic [1:0] idx, cur, first_idx, next_idx;
  logic first_last, next_last;
  logic [3:0] solid, nsolid, rest;
  logic [KBW-1:0] kmer [4];
  logic [CBW-1:0] cand [4];
  logic accept;
  // solid mask including the response now arriving, and the mask once the current survivor is taken
  always_comb begin
    accept = ip_valid && ready4_ip;
    nsolid = solid | (4'(lookup_rsp_solid) << idx);
    rest = solid & ~(4'd1 << cur);
  end
  solid_priority_pick u_first (.mask(nsolid), .idx(first_idx), .last(first_last));
  solid_priority_pick u_next (.mask(rest), .idx(next_idx), .last(next_last));
  // capture the group so later upstream changes cannot disturb it
  always_ff @(posedge clk) begin
    if (accept && state == IDLE) begin
      kmer <= '{kmerCandidate0, kmerCandidate1, kmerCandidate2, kmerCandidate3};
      cand <= '{candidate0, candidate1, candidate2, candidate3};
    end
  end
  // lookup / emit sequencing with all handshake outputs registered
  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      state <= IDLE;
      idx <= 2'd0;
      cur <= 2'd0;
      solid <= 4'd0;
      ready4_ip <= 1'b0;
      lookup_req <= 1'b0;
      lookup_kmer <= '0;
      op_valid <= 1'b0;
      candidate_out <= '0;
      position_out <= '0;
      op_last <= 1'b0;
      group_empty <= 1'b0;
    end else begin
      group_empty <= 1'b0;
      case (state)
        IDLE: begin
          if (accept) begin
            ready4_ip <= 1'b0;
            position_out <= direction ? position - PBW'(1) : position + PBW'(1);
            solid <= 4'd0;
            idx <= 2'd0;
            lookup_req <= 1'b1;
            lookup_kmer <= kmerCandidate0;
            state <= ISSUE;
          end else ready4_ip <= 1'b1;
        end
        ISSUE: begin
          if (lookup_ack) begin
            lookup_req <= 1'b0;
            state <= WAIT;
          end
        end
        WAIT: begin
          if (lookup_rsp_valid) begin
            solid <= nsolid;
            if (idx != 2'd3) begin
              idx <= idx + 2'd1;
              lookup_req <= 1'b1;
              lookup_kmer <= kmer[idx + 2'd1];
              state <= ISSUE;
            end else if (nsolid != 4'd0) begin
              op_valid <= 1'b1;
              cur <= first_idx;
              candidate_out <= cand[first_idx];
              op_last <= first_last;
              state <= EMIT;
            end else begin
              group_empty <= 1'b1;
              state <= IDLE;
            end
          end
        end
        EMIT: begin
          if (ready4_op) begin
            solid <= rest;
            if (op_last) begin
              op_valid <= 1'b0;
              op_last <= 1'b0;
              ready4_ip <= 1'b1;
              state <= IDLE;
            end else begin
              cur <= next_idx;
              candidate_out <= cand[next_idx];
              op_last <= next_last;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
`ifdef CANDIDATE_FILTER_STATS_EN
  logic done_grp, drop;
  // a group completes on its empty verdict or on the handshake of its last survivor
  always_comb begin
    done_grp = (state == WAIT && lookup_rsp_valid && idx == 2'd3 && nsolid == 4'd0) || (state == EMIT && ready4_op && op_last);
    drop = state == WAIT && lookup_rsp_valid && !lookup_rsp_solid;
  end
  // saturating group and dropped-k-mer counters
  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      stat_groups <= 16'd0;
      stat_dropped <= 16'd0;
    end else begin
      stat_groups <= stat_groups + 16'(done_grp && stat_groups != 16'hffff);
      stat_dropped <= stat_dropped + 16'(drop && stat_dropped != 16'hffff);
    end
  end
`endif
endmodule

// File: tb/tb_candidate_solidity_filter.sv
// tb_candidate_solidity_filter: randomized self-checking bench with a behavioural oracle and survivor model
module tb_candidate_solidity_filter;
  localparam int KB = 128;
  localparam int CB = 636;
  localparam int PB = 9;
  logic clk = 1'b0;
  logic rstb = 1'b1;
  logic ip_valid = 1'b0, ready4_ip;
  logic [KB-1:0] kmer0 = '0, kmer1 = '0, kmer2 = '0, kmer3 = '0;
  logic [CB-1:0] cand0 = '0, cand1 = '0, cand2 = '0, cand3 = '0;
  logic [PB-1:0] position = '0;
  logic direction = 1'b0;
  logic lookup_req, lookup_ack = 1'b0, lookup_rsp_valid = 1'b0, lookup_rsp_solid = 1'b0;
  logic [KB-1:0] lookup_kmer;
  logic op_valid, ready4_op = 1'b0, op_last, group_empty;
  logic [CB-1:0] candidate_out;
  logic [PB-1:0] position_out;
`ifdef CANDIDATE_FILTER_STATS_EN
  logic [15:0] stat_groups, stat_dropped;
`endif
  logic [KB-1:0] kq [4];
  logic [CB-1:0] cq [4];
  int checks = 0, passed = 0;
  int m_groups = 0, m_dropped = 0;

  always #5 clk = ~clk;

  candidate_solidity_filter dut (
`ifdef CANDIDATE_FILTER_STATS_EN
    .stat_groups(stat_groups), .stat_dropped(stat_dropped),
`endif
    .clk(clk), .rstb(rstb), .ip_valid(ip_valid), .ready4_ip(ready4_ip),
    .kmerCandidate0(kmer0), .kmerCandidate1(kmer1), .kmerCandidate2(kmer2), .kmerCandidate3(kmer3),
    .candidate0(cand0), .candidate1(cand1), .candidate2(cand2), .candidate3(cand3),
    .position(position), .direction(direction),
    .lookup_req(lookup_req), .lookup_kmer(lookup_kmer), .lookup_ack(lookup_ack),
    .lookup_rsp_valid(lookup_rsp_valid), .lookup_rsp_solid(lookup_rsp_solid),
    .op_valid(op_valid), .ready4_op(ready4_op), .candidate_out(candidate_out),
    .position_out(position_out), .op_last(op_last), .group_empty(group_empty)
  );

  task automatic check(input string tag, input logic [CB-1:0] got, input logic [CB-1:0] exp);
    checks++;
    if (got === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  function automatic logic [CB-1:0] rnd_vec(input int w);
    logic [CB-1:0] v = '0;
    for (int b = 0; b < w; b++) v[b] = 1'($urandom % 2);
    return v;
  endfunction

  task automatic check_stats();
`ifdef CANDIDATE_FILTER_STATS_EN
    check("stat_groups", CB'(stat_groups), CB'(m_groups));
    check("stat_dropped", CB'(stat_dropped), CB'(m_dropped));
`endif
  endtask

  // waits for ready, presents a fresh random group for one cycle, returns at cycle C+1
  task automatic start_group(input logic dir, input logic [PB-1:0] pos);
    for (int i = 0; i < 4; i++) begin
      kq[i] = KB'(rnd_vec(KB));
      kq[i][1:0] = 2'(i);
      cq[i] = rnd_vec(CB);
    end
    for (int t = 0; t < 20 && !ready4_ip; t++) @(negedge clk);
    check("ready_before_accept", CB'(ready4_ip), CB'(1));
    {kmer0, kmer1, kmer2, kmer3} = {kq[0], kq[1], kq[2], kq[3]};
    {cand0, cand1, cand2, cand3} = {cq[0], cq[1], cq[2], cq[3]};
    position = pos;
    direction = dir;
    ip_valid = 1'b1;
    @(negedge clk);
    ip_valid = 1'b0;
    kmer0 = KB'(rnd_vec(KB));
    kmer1 = KB'(rnd_vec(KB));
    cand0 = rnd_vec(CB);
    position = PB'($urandom);
    direction = ~dir;
  endtask

  // runs one group against the oracle model; mask bit i = solidity of k-mer i
  task automatic run_group(input logic [3:0] mask, input int ack_d, input int rsp_d, input int mode,
                           input logic dir, input logic [PB-1:0] pos);
    int q[$];
    int req_i = 0, wait_c = 0, pend = -1, first = 0;
    bit done = 0, tog = 1;
    logic [PB-1:0] exp_pos = PB'((int'(pos) + (dir ? -1 : 1) + 512) % 512);
    for (int i = 0; i < 4; i++) if (mask[i]) q.push_back(i);
    start_group(dir, pos);
    for (int k = 1; k < 400 && !done; k++) begin
      if (k > 1) @(negedge clk);
      if ((op_valid || group_empty) && first == 0) first = k;
      check("busy_not_ready", CB'(ready4_ip), CB'(0));
      ip_valid = 1'($urandom % 2);
      if (group_empty) begin
        check("empty_with_survivors", CB'(q.size()), CB'(0));
        check("empty_lookups", CB'(req_i), CB'(4));
        done = 1;
        m_groups++;
      end
      if (op_valid) begin
        if (q.size() == 0) check("spurious_op_valid", CB'(op_valid), CB'(0));
        else begin
          check("candidate_out", candidate_out, cq[q[0]]);
          check("position_out", CB'(position_out), CB'(exp_pos));
          check("op_last", CB'(op_last), CB'(q.size() == 1));
        end
        ready4_op = mode == 0 ? 1'b1 : mode == 1 ? tog : 1'($urandom % 2);
        tog = !tog;
        if (ready4_op && q.size() > 0) begin
          void'(q.pop_front());
          if (q.size() == 0) begin
            done = 1;
            m_groups++;
          end
        end
      end else ready4_op = (mode == 0);
      lookup_ack = 1'b0;
      lookup_rsp_valid = 1'b0;
      lookup_rsp_solid = 1'($urandom % 2);
      if (pend >= 0) begin
        if (pend == 0) begin
          lookup_rsp_valid = 1'b1;
          lookup_rsp_solid = mask[req_i];
          if (!mask[req_i]) m_dropped++;
          req_i++;
          pend = -1;
        end else pend--;
      end else if (lookup_req) begin
        check("lookup_count", CB'(req_i < 4), CB'(1));
        check("lookup_kmer", CB'(lookup_kmer), CB'(kq[req_i % 4]));
        if (wait_c == ack_d) begin
          lookup_ack = 1'b1;
          pend = rsp_d;
          wait_c = 0;
        end else wait_c++;
      end else if (op_valid) begin
        lookup_rsp_valid = 1'($urandom % 2);
        lookup_rsp_solid = 1'b1;
      end
    end
    check("group_completed", CB'(done), CB'(1));
    if (ack_d == 0 && rsp_d == 0) check("first_out_cycle", CB'(first), CB'(9));
    @(negedge clk);
    ip_valid = 1'b0;
    lookup_ack = 1'b0;
    lookup_rsp_valid = 1'b0;
    ready4_op = 1'b0;
    check("ready_after_group", CB'(ready4_ip), CB'(1));
    check("idle_op_valid", CB'(op_valid), CB'(0));
    check_stats();
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_ready4_ip"}, CB'(ready4_ip), CB'(0));
    check({tag, "_lookup_req"}, CB'(lookup_req), CB'(0));
    check({tag, "_lookup_kmer"}, CB'(lookup_kmer), CB'(0));
    check({tag, "_op_valid"}, CB'(op_valid), CB'(0));
    check({tag, "_candidate_out"}, candidate_out, CB'(0));
    check({tag, "_position_out"}, CB'(position_out), CB'(0));
    check({tag, "_op_last"}, CB'(op_last), CB'(0));
    check({tag, "_group_empty"}, CB'(group_empty), CB'(0));
  endtask

  initial begin
    #2 rstb = 1'b0;
    repeat (2) @(negedge clk);
    check_all_zero("reset");
    rstb = 1'b1;
    @(negedge clk);
    check("ready_after_reset", CB'(ready4_ip), CB'(1));
    run_group(4'b0101, 0, 0, 0, 1'b0, 9'd10);
    run_group(4'b0000, 0, 0, 0, 1'b1, 9'd0);
    run_group(4'b0110, 3, 5, 0, 1'b0, PB'($urandom));
    run_group(4'b1111, 0, 0, 1, 1'b0, 9'd100);
    run_group(4'b1111, 0, 0, 0, 1'b0, 9'd511);
    start_group(1'b0, 9'd50);
    check("abort_lookup_req", CB'(lookup_req), CB'(1));
    lookup_ack = 1'b1;
    @(negedge clk);
    lookup_ack = 1'b0;
    rstb = 1'b0;
    #1 check_all_zero("abort");
    @(negedge clk);
    rstb = 1'b1;
    lookup_rsp_valid = 1'b1;
    lookup_rsp_solid = 1'b1;
    @(negedge clk);
    lookup_rsp_valid = 1'b0;
    check("stray_op_valid", CB'(op_valid), CB'(0));
    check("stray_lookup_req", CB'(lookup_req), CB'(0));
    check("stray_group_empty", CB'(group_empty), CB'(0));
    check("stray_ready", CB'(ready4_ip), CB'(1));
    m_groups = 0;
    m_dropped = 0;
    check_stats();
    run_group(4'b0100, 0, 0, 0, 1'b1, 9'd200);
    run_group(4'b1111, 1, 2, 2, 1'b0, 9'd7);
    run_group(4'b0000, 2, 0, 0, 1'b1, 9'd300);
`ifdef CANDIDATE_FILTER_STATS_EN
    check("stat_groups_three", CB'(stat_groups), CB'(3));
    check("stat_dropped_seven", CB'(stat_dropped), CB'(7));
`endif
    for (int g = 0; g < 12; g++)
      run_group(4'($urandom), int'($urandom_range(0, 3)), int'($urandom_range(0, 4)),
                int'($urandom_range(0, 2)), 1'($urandom % 2), PB'($urandom));
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
